// File: rtl/msgPass_config_pkg.sv
// ============================================================================
// Module : msgPass_config_pkg
// Brief  : Shared types and defaults for the message-pass read-address generator.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package msgPass_config_pkg;

    localparam int c_BUFF_DEPTH_DEF = 16;
    localparam int c_DRC_LAT_DEF    = 2;

    // History fields are sized for the widest supported window/loop counters.
    localparam int c_HIST_ADDR_W    = 16;
    localparam int c_HIST_ITER_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2,
        ST_DRAIN  = 2'd3
    } msgpass_addrgen_state_e;

    typedef struct packed {
        logic [c_HIST_ADDR_W-1:0] addr;
        logic [c_HIST_ITER_W-1:0] iter;
        logic                     valid;
    } msgpass_addrgen_hist_t;

endpackage

`default_nettype wire

// File: rtl/msgpass_drc_hist.sv
// ============================================================================
// Module : msgpass_drc_hist
// Brief  : DEPTH-deep shift register of issued addresses awaiting DRC verdict.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module msgpass_drc_hist
    import msgPass_config_pkg::*;
#(
    parameter int DEPTH = c_DRC_LAT_DEF
)(
    input  logic                  sys_clk,
    input  logic                  rstn,
    input  logic                  i_push,
    input  logic                  i_flush,
    input  msgpass_addrgen_hist_t i_entry,
    output msgpass_addrgen_hist_t o_tail,
    output logic                  o_any_valid
);

    msgpass_addrgen_hist_t r_hist [DEPTH];

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
        end else if (i_push) begin
            r_hist[0] <= i_entry;
            for (int i = 1; i < DEPTH; i++) r_hist[i] <= r_hist[i-1];
        end
    end

    assign o_tail = r_hist[DEPTH-1];

    // The tail is consumed in the current cycle, so only the entries that
    // survive the next shift count as still pending.
    always_comb begin
        o_any_valid = 1'b0;
        for (int i = 0; i < DEPTH-1; i++) begin
            o_any_valid = o_any_valid | r_hist[i].valid;
        end
    end

endmodule

`default_nettype wire

// File: rtl/msgpass_rqst_addr_gen.sv
// ============================================================================
// Module : msgpass_rqst_addr_gen
// Brief  : Windowed, multi-pass buffer read-address generator with DRC replay.
//          Optional DRC event counter enabled by MSGPASS_ADDRGEN_DRC_CNT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module msgpass_rqst_addr_gen
    import msgPass_config_pkg::*;
#(
    parameter int BUFF_DEPTH = c_BUFF_DEPTH_DEF,
    parameter int ADDR_WIDTH = $clog2(BUFF_DEPTH),
    parameter int DRC_NUM    = 1,
    parameter int DRC_LAT    = c_DRC_LAT_DEF,
    parameter int LOOP_WIDTH = 4
)(
    input  logic                  sys_clk,
    input  logic                  rstn,
    input  logic                  begin_i,
    input  logic                  end_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [ADDR_WIDTH-1:0] end_addr_i,
    input  logic [LOOP_WIDTH-1:0] loop_num_i,
    input  logic [DRC_NUM-1:0]    is_drc_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  cen_o,
    output logic                  busy_o,
    output logic                  done_o
`ifdef MSGPASS_ADDRGEN_DRC_CNT_EN
    ,
    output logic [15:0]           drc_cnt_o
`endif
);

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(BUFF_DEPTH - 1);

    function automatic logic [ADDR_WIDTH-1:0] f_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == c_LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    msgpass_addrgen_state_e r_state, w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_start, r_end, r_addr, r_rp_addr;
    logic [LOOP_WIDTH-1:0] r_loop, r_cur_iter, r_rp_iter;
    logic                  r_cen, r_busy, r_done;

    logic [ADDR_WIDTH-1:0] w_addr_nxt, w_rp_addr_nxt;
    logic [LOOP_WIDTH-1:0] w_iter_nxt, w_rp_iter_nxt;
    logic                  w_cen_nxt, w_done_nxt, w_flush, w_accept;

    msgpass_addrgen_hist_t w_push_entry, w_tail;
    logic                  w_hist_any;

    assign w_push_entry.addr  = c_HIST_ADDR_W'(r_addr);
    assign w_push_entry.iter  = c_HIST_ITER_W'(r_cur_iter);
    assign w_push_entry.valid = r_cen;

    msgpass_drc_hist #(
        .DEPTH       (DRC_LAT)
    ) u_hist (
        .sys_clk     (sys_clk),
        .rstn        (rstn),
        .i_push      (r_busy),
        .i_flush     (w_flush),
        .i_entry     (w_push_entry),
        .o_tail      (w_tail),
        .o_any_valid (w_hist_any)
    );

    logic                  w_drc_hit, w_tail_is_end, w_tail_final, w_cur_is_end, w_cur_final;
    logic [ADDR_WIDTH-1:0] w_tail_addr;
    logic [LOOP_WIDTH-1:0] w_tail_iter;

    assign w_drc_hit     = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && w_tail.valid && (|is_drc_i);
    assign w_tail_addr   = w_tail.addr[ADDR_WIDTH-1:0];
    assign w_tail_iter   = w_tail.iter[LOOP_WIDTH-1:0];
    assign w_tail_is_end = (w_tail.addr == c_HIST_ADDR_W'(r_end));
    assign w_tail_final  = w_tail_is_end && (w_tail.iter == c_HIST_ITER_W'(r_loop));
    assign w_cur_is_end  = (r_addr == r_end);
    assign w_cur_final   = w_cur_is_end && (r_cur_iter == r_loop);

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_iter_nxt    = r_cur_iter;
        w_cen_nxt     = 1'b0;
        w_done_nxt    = 1'b0;
        w_rp_addr_nxt = r_rp_addr;
        w_rp_iter_nxt = r_rp_iter;
        w_flush       = 1'b0;
        w_accept      = 1'b0;

        if ((r_state != ST_IDLE) && end_i) begin
            w_state_nxt = ST_IDLE;
            w_flush     = 1'b1;
        end else if (w_drc_hit) begin
            // Replay resumes at the successor of the faulted address.
            w_flush = 1'b1;
            if (w_tail_final) begin
                w_state_nxt = ST_DRAIN;
            end else begin
                w_state_nxt = ST_BUBBLE;
                if (w_tail_is_end) begin
                    w_rp_addr_nxt = r_start;
                    w_rp_iter_nxt = w_tail_iter + LOOP_WIDTH'(1);
                end else begin
                    w_rp_addr_nxt = f_inc(w_tail_addr);
                    w_rp_iter_nxt = w_tail_iter;
                end
            end
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (begin_i && !end_i) begin
                        w_accept    = 1'b1;
                        w_flush     = 1'b1;
                        w_state_nxt = ST_RUN;
                        w_addr_nxt  = start_addr_i;
                        w_iter_nxt  = '0;
                        w_cen_nxt   = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_cur_final) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_cen_nxt = 1'b1;
                        if (w_cur_is_end) begin
                            w_addr_nxt = r_start;
                            w_iter_nxt = r_cur_iter + LOOP_WIDTH'(1);
                        end else begin
                            w_addr_nxt = f_inc(r_addr);
                        end
                    end
                end
                ST_BUBBLE: begin
                    w_state_nxt = ST_RUN;
                    w_addr_nxt  = r_rp_addr;
                    w_iter_nxt  = r_rp_iter;
                    w_cen_nxt   = 1'b1;
                end
                ST_DRAIN: begin
                    if (!w_hist_any) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_cur_iter <= '0;
            r_cen      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rp_addr  <= '0;
            r_rp_iter  <= '0;
            r_start    <= '0;
            r_end      <= '0;
            r_loop     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_cur_iter <= w_iter_nxt;
            r_cen      <= w_cen_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= w_done_nxt;
            r_rp_addr  <= w_rp_addr_nxt;
            r_rp_iter  <= w_rp_iter_nxt;
            if (w_accept) begin
                r_start <= start_addr_i;
                r_end   <= end_addr_i;
                r_loop  <= loop_num_i;
            end
        end
    end

    assign addr_o = r_addr;
    assign cen_o  = r_cen;
    assign busy_o = r_busy;
    assign done_o = r_done;

`ifdef MSGPASS_ADDRGEN_DRC_CNT_EN
    logic [15:0] r_drc_cnt;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_drc_cnt <= '0;
        end else if (w_accept) begin
            r_drc_cnt <= '0;
        end else if (w_drc_hit && !end_i && (r_drc_cnt != 16'hFFFF)) begin
            r_drc_cnt <= r_drc_cnt + 16'd1;
        end
    end

    assign drc_cnt_o = r_drc_cnt;
`endif

endmodule

`default_nettype wire
